ram_burst_reader: RTL and testbench

RAM_BURST_READER -- requirements
Module: ram_burst_reader

---
 rtl/ram_burst_reader.sv | 259 +++++++++++++++++++++++++
 tb/tb_ram_burst_reader.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_burst_reader.sv
// ============================================================================
// ram_burst_reader
//
// Purpose:
//   Reads a burst of consecutive words from a synchronous single-port RAM and
//   presents them as a valid/ready stream. Reads are issued one per cycle
//   into a 2-stage in-flight pipe (address stage, RAM stage). They land in a
//   4-entry output FIFO. A read is only issued when the FIFO is sure to have
//   room for it, so back-pressure on the stream never drops data.
//
// Configuration:
//   RAM_BURST_READER_WRAP_EN
//     defined   : burst addresses wrap modulo DEPTH, every request accepted,
//                 err_o tied low.
//     undefined : a request whose range runs past the end of the RAM
//                 (base_addr_i + len_i > DEPTH) is rejected with an err_o
//                 pulse and no reads.
//
// Parameters:
//   WIDTH  data word width
//   DEPTH  number of RAM words; AW = $clog2(DEPTH)
//
// Ports:
//   clk_i        clock, all logic on rising edge
//   rst_ni       asynchronous active-low reset
//   start_i      burst request, only looked at while idle
//   base_addr_i  first RAM word of the burst (sampled with start_i)
//   len_i        beat count 0..DEPTH (sampled with start_i)
//   mem_addr_o   registered RAM read address
//   mem_wr_o     RAM write strobe, always 0
//   mem_dout_i   RAM read data, valid one edge after mem_addr_o
//   out_data_o   stream data (FIFO head, 0 when empty)
//   out_valid_o  stream valid
//   out_ready_i  stream ready
//   busy_o       high while a burst is running or draining
//   done_o       one-cycle pulse after the last beat of a burst transfers
//   err_o        one-cycle pulse on a rejected request
// ============================================================================
module ram_burst_reader #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [AW-1:0]    base_addr_i,
    input  logic [AW:0]      len_i,
    output logic [AW-1:0]    mem_addr_o,
    output logic             mem_wr_o,
    input  logic [WIDTH-1:0] mem_dout_i,
    output logic [WIDTH-1:0] out_data_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o
);

    localparam int LW = AW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   base_q;
    logic [LW-1:0]   len_q;
    logic [LW-1:0]   issued_q;
    logic [LW-1:0]   popped_q;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic            addr_vld_q;
    logic            ram_vld_q;
    logic            done_q, done_d;

    logic [WIDTH-1:0] fifo_mem [4];
    logic [1:0]       wr_ptr_q;
    logic [1:0]       rd_ptr_q;
    logic [2:0]       count_q, count_d;

    logic            load;
    logic            issue;
    logic            push;
    logic            pop;
    logic            reject;
    logic [2:0]      in_flight;
    logic            credit_ok;

    // Next sequential RAM address. In wrap mode the last word is followed
    // by word 0 even when DEPTH is not a power of two.
    function automatic logic [AW-1:0] incr_addr(input logic [AW-1:0] a);
`ifdef RAM_BURST_READER_WRAP_EN
        if (a == AW'(DEPTH - 1)) begin
            return '0;
        end
        return a + AW'(1);
`else
        return a + AW'(1);
`endif
    endfunction

`ifdef RAM_BURST_READER_WRAP_EN
    assign reject = 1'b0;
    assign err_o  = 1'b0;
`else
    localparam int EW = AW + 2;

    logic [EW-1:0] req_end;
    logic          err_q;

    // One extra bit so base + len cannot overflow before the compare.
    assign req_end = EW'(base_addr_i) + EW'(len_i);
    assign reject  = (req_end > EW'(DEPTH));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else begin
            err_q <= (state_q == IDLE) && start_i && (len_i != '0) && reject;
        end
    end

    assign err_o = err_q;
`endif

    // Reads in the pipe have already claimed a FIFO slot, so the credit
    // check counts them as if they were stored. Pops in the current cycle
    // are deliberately ignored: that keeps the check simple and still
    // allows one read per cycle in steady state (1 stored + 2 in flight).
    assign in_flight = {2'b00, addr_vld_q} + {2'b00, ram_vld_q};
    assign credit_ok = (count_q + in_flight) < 3'd4;

    assign out_valid_o = (count_q != 3'd0);
    assign pop         = out_valid_o && out_ready_i;
    assign push        = ram_vld_q;

    always_comb begin
        state_d    = state_q;
        load       = 1'b0;
        issue      = 1'b0;
        done_d     = 1'b0;
        mem_addr_d = mem_addr_q;

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (len_i == '0) begin
                        done_d = 1'b1;
                    end else if (!reject) begin
                        load    = 1'b1;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if ((issued_q < len_q) && credit_ok) begin
                    issue = 1'b1;
                    if (issued_q + LW'(1) == len_q) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // The last read lands two cycles after it is issued, so
                // the final beat always leaves from this state.
                if (pop && (popped_q + LW'(1) == len_q)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (issue) begin
            mem_addr_d = (issued_q == '0) ? base_q : incr_addr(mem_addr_q);
        end
    end

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 3'd1;
        end else if (pop && !push) begin
            count_d = count_q - 3'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            base_q     <= '0;
            len_q      <= '0;
            issued_q   <= '0;
            popped_q   <= '0;
            mem_addr_q <= '0;
            addr_vld_q <= 1'b0;
            ram_vld_q  <= 1'b0;
            done_q     <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            done_q     <= done_d;
            mem_addr_q <= mem_addr_d;
            addr_vld_q <= issue;
            ram_vld_q  <= addr_vld_q;
            count_q    <= count_d;

            if (load) begin
                base_q   <= base_addr_i;
                len_q    <= len_i;
                issued_q <= '0;
                popped_q <= '0;
            end else begin
                if (issue) begin
                    issued_q <= issued_q + LW'(1);
                end
                if (pop) begin
                    popped_q <= popped_q + LW'(1);
                end
            end

            if (push) begin
                wr_ptr_q <= wr_ptr_q + 2'd1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 2'd1;
            end
        end
    end

    // Storage only; occupancy lives in count_q, so no reset is needed here.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= mem_dout_i;
        end
    end

    assign out_data_o = out_valid_o ? fifo_mem[rd_ptr_q] : '0;
    assign mem_addr_o = mem_addr_q;
    assign mem_wr_o   = 1'b0;
    assign busy_o     = (state_q == RUN) || (state_q == DRAIN);
    assign done_o     = done_q;

    a_count_bound : assert property (@(posedge clk_i) disable iff (!rst_ni)
        count_q <= 3'd4);

    a_no_overflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push && !pop && (count_q == 3'd4)));

    a_hold_stalled : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (out_valid_o && !out_ready_i) |=> (out_valid_o && $stable(out_data_o)));

endmodule

// File: tb/tb_ram_burst_reader.sv
// Self-checking bench for ram_burst_reader. A behavioural RAM sits on the
// memory port. For each burst, the expected beats are simply the RAM words
// base, base+1, ... taken modulo DEPTH. Timing expectations follow from the
// burst timeline: address after one edge, first beat after three edges,
// done right after the last transfer.
module tb_ram_burst_reader;

   localparam int WIDTH = 8;
   localparam int DEPTH = 8;
   localparam int AW    = $clog2(DEPTH);

   logic             clk = 1'b0;
   logic             rstN;
   logic             start;
   logic [AW-1:0]    baseAddr;
   logic [AW:0]      len;
   logic [AW-1:0]    memAddr;
   logic             memWr;
   logic [WIDTH-1:0] memDout;
   logic [WIDTH-1:0] outData;
   logic             outValid;
   logic             outReady;
   logic             busy;
   logic             done;
   logic             err;

   logic [WIDTH-1:0] ram [DEPTH];

   int testCount = 0;
   int failCount = 0;

   ram_burst_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk_i       (clk),
      .rst_ni      (rstN),
      .start_i     (start),
      .base_addr_i (baseAddr),
      .len_i       (len),
      .mem_addr_o  (memAddr),
      .mem_wr_o    (memWr),
      .mem_dout_i  (memDout),
      .out_data_o  (outData),
      .out_valid_o (outValid),
      .out_ready_i (outReady),
      .busy_o      (busy),
      .done_o      (done),
      .err_o       (err)
   );

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   // Synchronous-read RAM: data for an address appears one edge later.
   always @(posedge clk) memDout <= ram[memAddr];

   // Counts one comparison and reports it when observed and expected differ.
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      testCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Reference rule for request rejection.
   function automatic bit modelRejects(input int b, input int l);
`ifdef RAM_BURST_READER_WRAP_EN
      return 1'b0;
`else
      return (l != 0) && (b + l > DEPTH);
`endif
   endfunction

   // Runs one burst request and checks it against the reference model.
   // mode: 0 = ready always high, 1 = ready pattern 1,0,0,1, 2 = random ready.
   // pokeAt: cycle index at which a second start is pulsed while busy (-1 = none).
   // abortAfter: assert reset right after this many beats (0 = never).
   task automatic applyStimulus(input int b, input int l, input int mode, input int pokeAt, input int abortAfter);
      int               expBeats[$];
      int               beats;
      int               lastK;
      bit               rej;
      bit               sawDone;
      logic             prevValid;
      logic             prevReady;
      logic [WIDTH-1:0] prevData;

      rej = modelRejects(b, l);
      for (int i = 0; i < l; i++) expBeats.push_back(int'(ram[(b + i) % DEPTH]));

      @(negedge clk);
      start    = 1'b1;
      baseAddr = AW'(b);
      len      = (AW+1)'(l);
      outReady = 1'b0;
      @(negedge clk);
      start = 1'b0;

      checkOutput("mem_wr_low", memWr, 0);

      if (l == 0 || rej) begin
         checkOutput("done_on_empty", done, (l == 0));
         checkOutput("err_on_reject", err, rej);
         checkOutput("busy_not_taken", busy, 0);
         for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checkOutput("no_valid_after_nop", outValid, 0);
            checkOutput("done_single", done, 0);
            checkOutput("err_single", err, 0);
            checkOutput("busy_stays_low", busy, 0);
         end
         return;
      end

      checkOutput("busy_on_start", busy, 1);
      checkOutput("err_quiet", err, 0);
      checkOutput("done_quiet", done, 0);

      beats     = 0;
      lastK     = -10;
      sawDone   = 1'b0;
      prevValid = 1'b0;
      prevReady = 1'b0;
      prevData  = '0;

      for (int k = 0; k < 400; k++) begin
         if (k > 0) @(negedge clk);

         if (k == 1) checkOutput("mem_addr_base", memAddr, b);
         if (k < 3)  checkOutput("no_early_valid", outValid, 0);
         if (k == 3) checkOutput("first_valid_latency", outValid, 1);

         if (prevValid && !prevReady) begin
            checkOutput("valid_held_stalled", outValid, 1);
            checkOutput("data_held_stalled", outData, prevData);
         end

         if (done) begin
            sawDone = 1'b1;
            checkOutput("done_after_last", k, lastK + 1);
            checkOutput("busy_drops_with_done", busy, 0);
            checkOutput("beat_count", beats, l);
            checkOutput("valid_low_after_done", outValid, 0);
            break;
         end

         if (k == pokeAt) begin
            start    = 1'b1;
            baseAddr = AW'(5);
            len      = (AW+1)'(3);
         end else begin
            start = 1'b0;
         end

         case (mode)
            0:       outReady = 1'b1;
            1:       outReady = ((k % 4) == 0) || ((k % 4) == 3);
            default: outReady = 1'($urandom_range(0, 1));
         endcase

         if (outValid && outReady) begin
            if (expBeats.size() == 0) begin
               checkOutput("extra_beat", outData, 32'hFFFF_FFFF);
            end else begin
               checkOutput("beat_data", outData, expBeats.pop_front());
            end
            if (mode == 0) checkOutput("beat_cycle", k, 3 + beats);
            beats++;
            if (beats == l) lastK = k;
            if (beats == abortAfter) begin
               // Reset lands between edges; outputs must clear without a clock.
               @(posedge clk);
               #2;
               start    = 1'b0;
               outReady = 1'b0;
               rstN     = 1'b0;
               #1;
               checkOutput("abort_valid", outValid, 0);
               checkOutput("abort_busy", busy, 0);
               checkOutput("abort_mem_addr", memAddr, 0);
               checkOutput("abort_data", outData, 0);
               checkOutput("abort_done", done, 0);
               checkOutput("abort_err", err, 0);
               @(negedge clk);
               rstN = 1'b1;
               return;
            end
         end

         prevValid = outValid;
         prevReady = outReady;
         prevData  = outData;
      end

      start = 1'b0;
      if (!sawDone) begin
         checkOutput("done_timeout", 0, 1);
      end else begin
         @(negedge clk);
         checkOutput("done_one_cycle", done, 0);
      end
      outReady = 1'b0;
   endtask

   initial begin
      rstN     = 1'b0;
      start    = 1'b0;
      baseAddr = '0;
      len      = '0;
      outReady = 1'b0;
      for (int i = 0; i < DEPTH; i++) ram[i] = WIDTH'(8'hA0 + i);

      repeat (2) @(negedge clk);
      checkOutput("reset_valid", outValid, 0);
      checkOutput("reset_busy", busy, 0);
      checkOutput("reset_done", done, 0);
      checkOutput("reset_err", err, 0);
      checkOutput("reset_mem_addr", memAddr, 0);
      checkOutput("reset_data", outData, 0);
      checkOutput("reset_mem_wr", memWr, 0);
      rstN = 1'b1;
      @(negedge clk);

      applyStimulus(2, 4, 0, -1, 0);
      applyStimulus(0, 8, 1, -1, 0);
      applyStimulus(6, 4, 0, -1, 0);
      applyStimulus(3, 0, 0, -1, 0);
      applyStimulus(0, 5, 0, 2, 0);
      applyStimulus(0, 8, 0, -1, 2);
      applyStimulus(1, 2, 0, -1, 0);
      applyStimulus(7, 1, 1, -1, 0);
      applyStimulus(0, 8, 0, -1, 0);

      for (int n = 0; n < 40; n++) begin
         for (int i = 0; i < DEPTH; i++) ram[i] = WIDTH'($urandom);
         applyStimulus(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, DEPTH)),
                       int'($urandom_range(0, 2)), int'($urandom_range(0, 12)) - 4, 0);
      end

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
